// File: rtl/crossing_pkg.sv
// Shared types and helpers for the multi-track level-crossing controller.
package crossing_pkg;

  // Shared gate/signal sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARN   = 3'd1,
    CLOSED = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } state_e;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/track_occupancy.sv
// One track: sensor edge detect, saturating train count, occupied flag
// and a continuous-occupancy timer that flags a stuck train.
module track_occupancy
  import crossing_pkg::*;
#(
  parameter int CNT_W          = 2,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sensor_a,
  input  logic i_sensor_b,
  output logic o_occupied,
  output logic o_timeout
);

  localparam int               TW      = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    TO_VAL  = TW'(TIMEOUT_CYCLES);

  logic             r_prev_a, r_prev_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_occ;
  logic [TW-1:0]    r_tmr;

  logic             w_rise_a, w_rise_b;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Rising edges and next count; simultaneous A and B rises cancel out.
  always_comb begin
    w_rise_a  = i_sensor_a & ~r_prev_a;
    w_rise_b  = i_sensor_b & ~r_prev_b;
    w_cnt_nxt = r_cnt;
    if (w_rise_a && !w_rise_b) begin
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_rise_b && !w_rise_a) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // Edge history, count, occupied flag and saturating occupancy timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
      r_cnt    <= '0;
      r_occ    <= 1'b0;
      r_tmr    <= '0;
    end else begin
      r_prev_a <= i_sensor_a;
      r_prev_b <= i_sensor_b;
      r_cnt    <= w_cnt_nxt;
      r_occ    <= (w_cnt_nxt != '0);
      if (!r_occ)               r_tmr <= '0;
      else if (r_tmr != TO_VAL) r_tmr <= r_tmr + 1'b1;
    end
  end

  assign o_occupied = r_occ;
  assign o_timeout  = (r_tmr == TO_VAL);

endmodule

// File: rtl/multi_track_crossing.sv
// N-track level-crossing controller: merges per-track occupancy and drives
// one shared gate and warning lamp through warn/closed/hold phases, with a
// sticky fail-safe fault on any stuck track.
module multi_track_crossing
  import crossing_pkg::*;
#(
  parameter int N_TRACKS       = 2,
  parameter int CNT_W          = 2,
  parameter int WARN_CYCLES    = 4,
  parameter int HOLD_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_TRACKS-1:0] sensor_A,
  input  logic [N_TRACKS-1:0] sensor_B,
  output logic                gate,
  output logic                signal,
  output logic [N_TRACKS-1:0] occupied,
  output logic                fault
);

  localparam int            PW       = clog2(((WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES) + 1);
  localparam logic [PW-1:0] WARN_END = PW'(WARN_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_END = PW'(HOLD_CYCLES - 1);

  logic [N_TRACKS-1:0] w_occ, w_to;
  logic                w_any_occ, w_any_to;

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_ph, w_ph_nxt;
  logic          r_gate, r_signal, r_fault;

  for (genvar g = 0; g < N_TRACKS; g++) begin : g_trk
    track_occupancy #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_trk (
      .clk        (clk),
      .reset      (reset),
      .i_sensor_a (sensor_A[g]),
      .i_sensor_b (sensor_B[g]),
      .o_occupied (w_occ[g]),
      .o_timeout  (w_to[g])
    );
  end

  assign w_any_occ = |w_occ;
  assign w_any_to  = |w_to;

  // Next state and phase timer; a timeout overrides any other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    case (r_state)
      IDLE: begin
        if (w_any_occ) begin
          w_state_nxt = WARN;
          w_ph_nxt    = '0;
        end
      end
      WARN: begin
        // Runs to completion even if the tracks clear meanwhile.
        if (r_ph == WARN_END) begin
          w_state_nxt = CLOSED;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      CLOSED: begin
        if (!w_any_occ) begin
          w_state_nxt = HOLD;
          w_ph_nxt    = '0;
        end
      end
      HOLD: begin
        if (w_any_occ) begin
          w_state_nxt = CLOSED;
          w_ph_nxt    = '0;
        end else if (r_ph == HOLD_END) begin
          w_state_nxt = IDLE;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = FAULT;
    endcase
    if (w_any_to) w_state_nxt = FAULT;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ph     <= '0;
      r_gate   <= 1'b0;
      r_signal <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph     <= w_ph_nxt;
      r_gate   <= (w_state_nxt == CLOSED) || (w_state_nxt == HOLD) || (w_state_nxt == FAULT);
      r_signal <= (w_state_nxt != IDLE);
      r_fault  <= (w_state_nxt == FAULT);
    end
  end

  assign gate     = r_gate;
  assign signal   = r_signal;
  assign fault    = r_fault;
  assign occupied = w_occ;

endmodule

// File: tb/tb_multi_track_crossing.sv
// Directed scenarios plus random sensor traffic, checked every cycle
// against a countdown-based behavioural model of the crossing.
`timescale 1ns/1ps
module tb_multi_track_crossing;

  localparam int N    = 2;
  localparam int CW   = 2;
  localparam int WC   = 4;
  localparam int HC   = 3;
  localparam int TO   = 50;
  localparam int CMAX = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_WARN = 1, P_CLOSED = 2, P_HOLD = 3, P_FAULT = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] sensor_A, sensor_B;
  logic         gate, signal, fault;
  logic [N-1:0] occupied;

  int total = 0;
  int bad   = 0;

  // model state
  int m_cnt [N];
  int m_tmr [N];
  bit m_pa  [N];
  bit m_pb  [N];
  bit m_occ [N];
  int m_phase;
  int m_left;

  multi_track_crossing #(
    .N_TRACKS(N), .CNT_W(CW), .WARN_CYCLES(WC), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sensor_A(sensor_A), .sensor_B(sensor_B),
    .gate(gate), .signal(signal), .occupied(occupied), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_tmr[i] = 0; m_pa[i] = 0; m_pb[i] = 0; m_occ[i] = 0;
    end
    m_phase = P_IDLE;
    m_left  = 0;
  endtask

  // One clock edge of the reference behaviour; decisions use pre-edge flags.
  task automatic model_edge(input logic [N-1:0] a, input logic [N-1:0] b);
    bit old_any, old_to, ra, rb;
    old_any = 0;
    old_to  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_occ[i]) old_any = 1;
      if (m_tmr[i] >= TO) old_to = 1;
    end
    for (int i = 0; i < N; i++) begin
      m_tmr[i] = m_occ[i] ? ((m_tmr[i] < TO) ? m_tmr[i] + 1 : TO) : 0;
      ra = a[i] && !m_pa[i];
      rb = b[i] && !m_pb[i];
      if (ra && !rb && m_cnt[i] < CMAX) m_cnt[i]++;
      else if (rb && !ra && m_cnt[i] > 0) m_cnt[i]--;
      m_occ[i] = (m_cnt[i] != 0);
      m_pa[i]  = a[i];
      m_pb[i]  = b[i];
    end
    if (old_to || m_phase == P_FAULT) m_phase = P_FAULT;
    else case (m_phase)
      P_IDLE:   if (old_any) begin m_phase = P_WARN; m_left = WC; end
      P_WARN:   begin m_left--; if (m_left == 0) m_phase = P_CLOSED; end
      P_CLOSED: if (!old_any) begin m_phase = P_HOLD; m_left = HC; end
      P_HOLD: begin
        if (old_any) m_phase = P_CLOSED;
        else begin m_left--; if (m_left == 0) m_phase = P_IDLE; end
      end
      default: m_phase = P_FAULT;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eo;
    for (int i = 0; i < N; i++) eo[i] = m_occ[i];
    chk({tag, "_gate"},   32'(gate),     32'(m_phase >= P_CLOSED));
    chk({tag, "_signal"}, 32'(signal),   32'(m_phase != P_IDLE));
    chk({tag, "_occ"},    32'(occupied), 32'(eo));
    chk({tag, "_fault"},  32'(fault),    32'(m_phase == P_FAULT));
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    sensor_A = a;
    sensor_B = b;
    @(posedge clk);
    model_edge(a, b);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step('0, '0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    sensor_A = '0;
    sensor_B = '0;
    model_reset();
    #2;
    chk("rst_gate",   32'(gate),     0);
    chk("rst_signal", 32'(signal),   0);
    chk("rst_occ",    32'(occupied), 0);
    chk("rst_fault",  32'(fault),    0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    reset = 1'b0; sensor_A = '0; sensor_B = '0;
    model_reset();
    do_reset();

    // 1: single train, exact phase timing
    idle(3, "t1");
    step(2'b01, 2'b00, "t1");  chk("t1_sig_p0", 32'(signal), 0);
    step(2'b00, 2'b00, "t1");  chk("t1_sig_p1", 32'(signal), 1); chk("t1_gate_p1", 32'(gate), 0);
    idle(3, "t1");             chk("t1_gate_p4", 32'(gate), 0);
    step(2'b00, 2'b00, "t1");  chk("t1_gate_p5", 32'(gate), 1);
    idle(14, "t1");
    step(2'b00, 2'b01, "t1");
    idle(3, "t1");             chk("t1_gate_b3", 32'(gate), 1);
    step(2'b00, 2'b00, "t1");  chk("t1_gate_b4", 32'(gate), 0); chk("t1_sig_b4", 32'(signal), 0);
    idle(3, "t1");

    // 2: overlapping trains on two tracks
    step(2'b01, 2'b00, "t2"); idle(9, "t2");
    step(2'b10, 2'b00, "t2"); idle(4, "t2");
    step(2'b00, 2'b01, "t2"); idle(14, "t2");
    chk("t2_gate_hold", 32'(gate), 1);
    step(2'b00, 2'b10, "t2"); idle(3, "t2");
    chk("t2_gate_b1_3", 32'(gate), 1);
    idle(3, "t2");
    chk("t2_gate_end", 32'(gate), 0);

    // 3: re-entry one cycle into HOLD
    step(2'b01, 2'b00, "t3"); idle(10, "t3");
    step(2'b00, 2'b01, "t3");
    step(2'b00, 2'b00, "t3");
    step(2'b01, 2'b00, "t3");
    for (int k = 0; k < 10; k++) begin
      step(2'b00, 2'b00, "t3");
      chk("t3_gate_up", 32'(gate), 1);
    end
    step(2'b00, 2'b01, "t3"); idle(6, "t3");

    // 4: same-edge A and B rise, then spurious B on an empty track
    step(2'b01, 2'b00, "t4"); idle(6, "t4");
    step(2'b01, 2'b01, "t4");
    idle(2, "t4");            chk("t4_occ_same", 32'(occupied[0]), 1);
    step(2'b00, 2'b01, "t4"); idle(6, "t4");
    step(2'b00, 2'b01, "t4");
    idle(2, "t4");            chk("t4_occ_spur", 32'(occupied), 0); chk("t4_sig_spur", 32'(signal), 0);

    // 5: stuck train trips the fault; only reset clears it
    step(2'b01, 2'b00, "t5"); idle(40, "t5");
    chk("t5_fault_early", 32'(fault), 0);
    idle(20, "t5");
    chk("t5_fault", 32'(fault), 1);
    step(2'b00, 2'b01, "t5"); idle(5, "t5");
    chk("t5_fault_keep", 32'(fault), 1); chk("t5_gate_keep", 32'(gate), 1); chk("t5_sig_keep", 32'(signal), 1);
    do_reset();

    // 6: async reset pulse mid-CLOSED, then count saturation
    step(2'b01, 2'b00, "t6"); idle(8, "t6");
    chk("t6_closed", 32'(gate), 1);
    reset = 1'b0;
    #2;
    chk("t6_async_gate", 32'(gate), 0);
    chk("t6_async_sig",  32'(signal), 0);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin step(2'b01, 2'b00, "t6s"); step(2'b00, 2'b00, "t6s"); end
    for (int k = 0; k < 3; k++) begin step(2'b00, 2'b01, "t6s"); if (k < 2) step(2'b00, 2'b00, "t6s"); end
    chk("t6_sat_occ", 32'(occupied), 0);
    idle(8, "t6s");

    // random traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      ra = '0; rb = '0;
      for (int k = 0; k < 200; k++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 3) == 0) ra[i] = ~ra[i];
          if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
        end
        step(ra, rb, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
